// File: rtl/ps_pkg.sv
// Shared constants for the program-sequencer fetch stage: opcodes, decode field positions, FSM states.
// The HALT state exists only when PS_BKPT_EN is defined.
package ps_pkg;

    localparam int unsigned PS_PMA_W  = 16;
    localparam int unsigned PS_INST_W = 32;

    localparam int unsigned OP_HI    = 31;
    localparam int unsigned OP_LO    = 27;
    localparam int unsigned OP_W     = OP_HI - OP_LO + 1;
    localparam int unsigned BT26_POS = 26;
    localparam int unsigned BT5_HI   = 25;
    localparam int unsigned BT5_LO   = 5;
    localparam int unsigned BT5_W    = BT5_HI - BT5_LO + 1;

    localparam logic [OP_W-1:0] CPT_OP  = 5'b00001;
    localparam logic [OP_W-1:0] IDLE_OP = 5'b11111;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SLEEP = 2'd2
`ifdef PS_BKPT_EN
        ,
        ST_HALT  = 2'd3
`endif
    } ps_state_e;

endpackage

// File: rtl/ps_fetch_skid.sv
// One-entry instruction+pc holding buffer that catches the read returning during a stall.
// A flush drops the held entry; a write wins over a read in the same cycle.
module ps_fetch_skid
    import ps_pkg::*;
#(
    parameter int unsigned PMA_W  = PS_PMA_W,
    parameter int unsigned INST_W = PS_INST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              wr_en_i,
    input  logic [INST_W-1:0] wr_inst_i,
    input  logic [PMA_W-1:0]  wr_pc_i,
    input  logic              rd_en_i,
    output logic              vld_o,
    output logic [INST_W-1:0] inst_o,
    output logic [PMA_W-1:0]  pc_o
);

    logic              vld_q;
    logic [INST_W-1:0] inst_q;
    logic [PMA_W-1:0]  pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            inst_q <= '0;
            pc_q   <= '0;
        end else begin
            if (flush_i) begin
                vld_q <= 1'b0;
            end else if (wr_en_i) begin
                vld_q <= 1'b1;
            end else if (rd_en_i) begin
                vld_q <= 1'b0;
            end
            if (wr_en_i && !flush_i) begin
                inst_q <= wr_inst_i;
                pc_q   <= wr_pc_i;
            end
        end
    end

    assign vld_o  = vld_q;
    assign inst_o = inst_q;
    assign pc_o   = pc_q;

endmodule

// File: rtl/ps_inst_fetch.sv
// Program-sequencer fetch stage: PC, synchronous program-memory read, IR and compute-decode outputs.
// Define PS_BKPT_EN to add the breakpoint ports (ps_bkpt_arm/ps_bkpt_addr) and the HALT state.
module ps_inst_fetch
    import ps_pkg::*;
#(
    parameter int unsigned      PMA_W     = PS_PMA_W,
    parameter int unsigned      INST_W    = PS_INST_W,
    parameter logic [PMA_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst,
`ifdef PS_BKPT_EN
    input  logic              ps_bkpt_arm,
    input  logic [PMA_W-1:0]  ps_bkpt_addr,
`endif
    input  logic              ps_stall,
    input  logic              ps_jmp_en,
    input  logic [PMA_W-1:0]  ps_jmp_addr,
    input  logic              ps_wake,
    input  logic [INST_W-1:0] ps_pm_data,
    output logic [PMA_W-1:0]  ps_pm_addr,
    output logic              ps_pm_rd,
    output logic              ps_ir_vld,
    output logic [PMA_W-1:0]  ps_ir_pc,
    output logic              cpt_en,
    output logic              bt_26,
    output logic [BT5_W-1:0]  bt_5t25,
    output logic              ps_sleep
);

    ps_state_e          state_q, state_d;
    logic [PMA_W-1:0]   fpc_q;
    logic [PMA_W-1:0]   rd_pc_q;
    logic               resp_vld_q;
    logic               ir_vld_q;
    logic [PMA_W-1:0]   ir_pc_q;
    logic               cpt_en_q;
    logic               bt_26_q;
    logic [BT5_W-1:0]   bt_5t25_q;
    logic               sleep_q;
    logic               sleep_d;

    logic               skid_vld;
    logic [INST_W-1:0]  skid_inst;
    logic [PMA_W-1:0]   skid_pc;

    logic               rd_c;
    logic               load_c;
    logic               skid_wr_c;
    logic               skid_rd_c;
    logic               ld_idle_c;
    logic               stop_c;
    logic               is_cpt_c;
    logic [INST_W-1:0]  ld_inst;
    logic [PMA_W-1:0]   ld_pc;
    logic               unused_low_c;
`ifdef PS_BKPT_EN
    logic               ld_bkpt_c;
`endif

    // IR source selection: skid drains first, then the word returning from memory.
    always_comb begin
        rd_c      = (state_q == ST_RUN) && !ps_stall;
        load_c    = 1'b0;
        skid_rd_c = 1'b0;
        skid_wr_c = 1'b0;
        ld_inst   = ps_pm_data;
        ld_pc     = rd_pc_q;
        if (!ps_jmp_en) begin
            if (ps_stall) begin
                skid_wr_c = resp_vld_q;
            end else if (skid_vld) begin
                load_c    = 1'b1;
                skid_rd_c = 1'b1;
                ld_inst   = skid_inst;
                ld_pc     = skid_pc;
            end else begin
                load_c = resp_vld_q;
            end
        end
        is_cpt_c  = (ld_inst[OP_HI:OP_LO] == CPT_OP);
        ld_idle_c = load_c && (ld_inst[OP_HI:OP_LO] == IDLE_OP);
`ifdef PS_BKPT_EN
        ld_bkpt_c = load_c && ps_bkpt_arm && (ld_pc == ps_bkpt_addr);
        stop_c    = ld_idle_c || ld_bkpt_c;
`else
        stop_c    = ld_idle_c;
`endif
    end

    assign unused_low_c = ^ld_inst[BT5_LO-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN: begin
                if (!ps_jmp_en) begin
`ifdef PS_BKPT_EN
                    if (ld_bkpt_c) begin
                        state_d = ST_HALT;
                    end else
`endif
                    if (ld_idle_c) begin
                        state_d = ST_SLEEP;
                    end
                end
            end
            ST_SLEEP: if (ps_jmp_en || ps_wake) state_d = ST_RUN;
`ifdef PS_BKPT_EN
            ST_HALT:  if (ps_jmp_en) state_d = ST_RUN;
`endif
            default:  state_d = ST_BOOT;
        endcase
`ifdef PS_BKPT_EN
        sleep_d = (state_d == ST_SLEEP) || (state_d == ST_HALT);
`else
        sleep_d = (state_d == ST_SLEEP);
`endif
    end

    // Jump beats IDLE/breakpoint, which beat the normal post-increment of the fetch pc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            fpc_q      <= RESET_VEC;
            rd_pc_q    <= '0;
            resp_vld_q <= 1'b0;
            ir_vld_q   <= 1'b0;
            ir_pc_q    <= '0;
            cpt_en_q   <= 1'b0;
            bt_26_q    <= 1'b0;
            bt_5t25_q  <= '0;
            sleep_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sleep_q    <= sleep_d;
            resp_vld_q <= rd_c && !ps_jmp_en && !stop_c;
            if (rd_c) begin
                rd_pc_q <= fpc_q;
            end
            if (ps_jmp_en) begin
                fpc_q <= ps_jmp_addr;
            end else if (stop_c) begin
                fpc_q <= ld_pc + PMA_W'(1);
            end else if (rd_c) begin
                fpc_q <= fpc_q + PMA_W'(1);
            end
            if (ps_jmp_en || (!ps_stall && !load_c)) begin
                ir_vld_q  <= 1'b0;
                cpt_en_q  <= 1'b0;
                bt_26_q   <= 1'b0;
                bt_5t25_q <= '0;
            end else if (load_c) begin
                ir_vld_q  <= 1'b1;
                ir_pc_q   <= ld_pc;
                cpt_en_q  <= is_cpt_c;
                bt_26_q   <= is_cpt_c && ld_inst[BT26_POS];
                bt_5t25_q <= is_cpt_c ? ld_inst[BT5_HI:BT5_LO] : '0;
            end
        end
    end

    ps_fetch_skid #(
        .PMA_W  (PMA_W),
        .INST_W (INST_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (ps_jmp_en || stop_c),
        .wr_en_i   (skid_wr_c),
        .wr_inst_i (ps_pm_data),
        .wr_pc_i   (rd_pc_q),
        .rd_en_i   (skid_rd_c),
        .vld_o     (skid_vld),
        .inst_o    (skid_inst),
        .pc_o      (skid_pc)
    );

    assign ps_pm_addr = fpc_q;
    assign ps_pm_rd   = rd_c;
    assign ps_ir_vld  = ir_vld_q;
    assign ps_ir_pc   = ir_pc_q;
    assign cpt_en     = cpt_en_q;
    assign bt_26      = bt_26_q;
    assign bt_5t25    = bt_5t25_q;
    assign ps_sleep   = sleep_q;

endmodule

// File: tb/tb_ps_inst_fetch.sv
// Directed bench for ps_inst_fetch: streaming, decode fields, stall, jump, IDLE/wake, wrap, async reset.
// Breakpoint scenario runs only when PS_BKPT_EN is defined.
module tb_ps_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ps_stall = 1'b0;
    logic        ps_jmp_en = 1'b0;
    logic [15:0] ps_jmp_addr = '0;
    logic        ps_wake = 1'b0;
    logic [31:0] ps_pm_data;
    logic [15:0] ps_pm_addr;
    logic        ps_pm_rd;
    logic        ps_ir_vld;
    logic [15:0] ps_ir_pc;
    logic        cpt_en;
    logic        bt_26;
    logic [20:0] bt_5t25;
    logic        ps_sleep;
`ifdef PS_BKPT_EN
    logic        ps_bkpt_arm = 1'b0;
    logic [15:0] ps_bkpt_addr = '0;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [31:0] mem [0:511];

    ps_inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
`ifdef PS_BKPT_EN
        .ps_bkpt_arm  (ps_bkpt_arm),
        .ps_bkpt_addr (ps_bkpt_addr),
`endif
        .ps_stall     (ps_stall),
        .ps_jmp_en    (ps_jmp_en),
        .ps_jmp_addr  (ps_jmp_addr),
        .ps_wake      (ps_wake),
        .ps_pm_data   (ps_pm_data),
        .ps_pm_addr   (ps_pm_addr),
        .ps_pm_rd     (ps_pm_rd),
        .ps_ir_vld    (ps_ir_vld),
        .ps_ir_pc     (ps_ir_pc),
        .cpt_en       (cpt_en),
        .bt_26        (bt_26),
        .bt_5t25      (bt_5t25),
        .ps_sleep     (ps_sleep)
    );

    always #5 clk = ~clk;

    // Synchronous program memory, one-cycle read latency.
    always @(posedge clk) begin
        if (ps_pm_rd) ps_pm_data <= mem[ps_pm_addr[8:0]];
    end

    // Leaves the bench just after reset release: the current cycle is the BOOT cycle (cycle 0).
    task automatic do_reset();
        rst = 1'b0;
        ps_stall = 1'b0;
        ps_jmp_en = 1'b0;
        ps_wake = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        if (ps_pm_addr !== 16'h0000) $display("FAIL reset_pm_addr: got %h want 0000", ps_pm_addr); else pass_cnt++;
        total_cnt++;
        if ({ps_pm_rd, ps_ir_vld, cpt_en, bt_26, ps_sleep} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {ps_pm_rd, ps_ir_vld, cpt_en, bt_26, ps_sleep}); else pass_cnt++;
        total_cnt++;
        if ({ps_ir_pc, bt_5t25} !== 37'h0) $display("FAIL reset_ir: got pc %h bt %h want 0", ps_ir_pc, bt_5t25); else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_stream();
        do_reset();
        @(negedge clk); // cycle 1
        if ({ps_pm_rd, ps_pm_addr} !== {1'b1, 16'h0000}) $display("FAIL c1_read: got rd %b addr %h want 1 0000", ps_pm_rd, ps_pm_addr); else pass_cnt++;
        total_cnt++;
        @(negedge clk); // cycle 2
        if ({ps_ir_vld, ps_pm_addr} !== {1'b0, 16'h0001}) $display("FAIL c2_state: got vld %b addr %h want 0 0001", ps_ir_vld, ps_pm_addr); else pass_cnt++;
        total_cnt++;
        ps_wake = 1'b1;
        @(negedge clk); // cycle 3
        ps_wake = 1'b0;
        if ({cpt_en, ps_ir_vld, ps_ir_pc} !== {1'b1, 1'b1, 16'h0000}) $display("FAIL c3_first_ir: got cpt %b vld %b pc %h want 1 1 0000", cpt_en, ps_ir_vld, ps_ir_pc); else pass_cnt++;
        total_cnt++;
        if ({ps_sleep, ps_pm_addr} !== {1'b0, 16'h0002}) $display("FAIL wake_in_run: got sleep %b addr %h want 0 0002", ps_sleep, ps_pm_addr); else pass_cnt++;
        total_cnt++;
        @(negedge clk); // cycle 4
        if ({ps_ir_pc, bt_26, bt_5t25} !== {16'h0001, 1'b1, 21'h000001}) $display("FAIL c4_decode: got pc %h b26 %b bt %h want 0001 1 000001", ps_ir_pc, bt_26, bt_5t25); else pass_cnt++;
        total_cnt++;
        @(negedge clk); // cycle 5
        if ({ps_ir_pc, cpt_en, bt_26, bt_5t25} !== {16'h0002, 1'b1, 1'b0, 21'h155555}) $display("FAIL c5_decode_aaa: got pc %h cpt %b b26 %b bt %h want 0002 1 0 155555", ps_ir_pc, cpt_en, bt_26, bt_5t25); else pass_cnt++;
        total_cnt++;
        @(negedge clk); // cycle 6
        if (ps_ir_pc !== 16'h0003) $display("FAIL c6_pc: got %h want 0003", ps_ir_pc); else pass_cnt++;
        total_cnt++;
    endtask

    // Continues from test_stream at cycle 6; IDLE sits at address 5.
    task automatic test_idle();
        @(negedge clk); // cycle 7
        if (ps_ir_pc !== 16'h0004) $display("FAIL c7_pc: got %h want 0004", ps_ir_pc); else pass_cnt++;
        total_cnt++;
        @(negedge clk); // cycle 8
        if ({ps_ir_vld, ps_ir_pc, cpt_en, ps_sleep, ps_pm_rd} !== {1'b1, 16'h0005, 1'b0, 1'b1, 1'b0}) $display("FAIL idle_enter: got vld %b pc %h cpt %b sleep %b rd %b want 1 0005 0 1 0", ps_ir_vld, ps_ir_pc, cpt_en, ps_sleep, ps_pm_rd); else pass_cnt++;
        total_cnt++;
        @(negedge clk); // cycle 9
        if ({ps_ir_vld, ps_sleep, ps_pm_rd, ps_pm_addr} !== {1'b0, 1'b1, 1'b0, 16'h0006}) $display("FAIL idle_next: got vld %b sleep %b rd %b addr %h want 0 1 0 0006", ps_ir_vld, ps_sleep, ps_pm_rd, ps_pm_addr); else pass_cnt++;
        total_cnt++;
        @(negedge clk); // cycle 10
        ps_wake = 1'b1;
        @(negedge clk); // cycle 11
        ps_wake = 1'b0;
        if ({ps_sleep, ps_pm_rd, ps_pm_addr} !== {1'b0, 1'b1, 16'h0006}) $display("FAIL wake_read: got sleep %b rd %b addr %h want 0 1 0006", ps_sleep, ps_pm_rd, ps_pm_addr); else pass_cnt++;
        total_cnt++;
        repeat (2) @(negedge clk); // cycle 13
        if ({ps_ir_vld, ps_ir_pc} !== {1'b1, 16'h0006}) $display("FAIL wake_ir: got vld %b pc %h want 1 0006", ps_ir_vld, ps_ir_pc); else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_stall();
        do_reset();
        repeat (4) @(negedge clk); // cycle 4
        ps_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if ({ps_ir_vld, ps_ir_pc, ps_pm_rd} !== {1'b1, 16'h0001, 1'b0}) $display("FAIL stall_hold_%0d: got vld %b pc %h rd %b want 1 0001 0", i, ps_ir_vld, ps_ir_pc, ps_pm_rd); else pass_cnt++;
            total_cnt++;
        end
        ps_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if ({ps_ir_vld, ps_ir_pc} !== {1'b1, 16'(2 + i)}) $display("FAIL stall_resume_%0d: got vld %b pc %h want 1 %h", i, ps_ir_vld, ps_ir_pc, 16'(2 + i)); else pass_cnt++;
            total_cnt++;
            if (i == 0 && bt_5t25 !== 21'h155555) $display("FAIL stall_skid_data: got %h want 155555", bt_5t25); else if (i == 0) pass_cnt++;
            if (i == 0) total_cnt++;
        end
    endtask

    task automatic test_jump();
        do_reset();
        repeat (4) @(negedge clk); // cycle k = 4
        ps_jmp_en = 1'b1;
        ps_jmp_addr = 16'h0100;
        @(negedge clk); // k+1
        ps_jmp_en = 1'b0;
        if ({ps_ir_vld, ps_pm_rd, ps_pm_addr} !== {1'b0, 1'b1, 16'h0100}) $display("FAIL jump_k1: got vld %b rd %b addr %h want 0 1 0100", ps_ir_vld, ps_pm_rd, ps_pm_addr); else pass_cnt++;
        total_cnt++;
        repeat (2) @(negedge clk); // k+3
        if ({ps_ir_vld, ps_ir_pc, bt_5t25} !== {1'b1, 16'h0100, 21'h000100}) $display("FAIL jump_k3: got vld %b pc %h bt %h want 1 0100 000100", ps_ir_vld, ps_ir_pc, bt_5t25); else pass_cnt++;
        total_cnt++;
        @(negedge clk); // k+4
        if ({ps_ir_pc, bt_26} !== {16'h0101, 1'b1}) $display("FAIL jump_k4: got pc %h b26 %b want 0101 1", ps_ir_pc, bt_26); else pass_cnt++;
        total_cnt++;
        ps_jmp_en = 1'b1;
        ps_jmp_addr = 16'hFFFE;
        @(negedge clk);
        ps_jmp_en = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if ({ps_ir_vld, ps_ir_pc} !== {1'b1, 16'hFFFE + 16'(i)}) $display("FAIL wrap_%0d: got vld %b pc %h want 1 %h", i, ps_ir_vld, ps_ir_pc, 16'hFFFE + 16'(i)); else pass_cnt++;
            total_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_jump_sleep();
        do_reset();
        repeat (9) @(negedge clk); // cycle 9, sleeping after IDLE at 5
        if (ps_sleep !== 1'b1) $display("FAIL jsleep_pre: got sleep %b want 1", ps_sleep); else pass_cnt++;
        total_cnt++;
        ps_jmp_en = 1'b1;
        ps_jmp_addr = 16'h0010;
        @(negedge clk);
        ps_jmp_en = 1'b0;
        if ({ps_sleep, ps_pm_rd, ps_pm_addr} !== {1'b0, 1'b1, 16'h0010}) $display("FAIL jsleep_read: got sleep %b rd %b addr %h want 0 1 0010", ps_sleep, ps_pm_rd, ps_pm_addr); else pass_cnt++;
        total_cnt++;
        repeat (2) @(negedge clk);
        if ({ps_ir_vld, ps_ir_pc} !== {1'b1, 16'h0010}) $display("FAIL jsleep_ir: got vld %b pc %h want 1 0010", ps_ir_vld, ps_ir_pc); else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        if ({ps_pm_addr, ps_ir_pc, bt_5t25} !== 53'h0) $display("FAIL areset_regs: got addr %h pc %h bt %h want 0", ps_pm_addr, ps_ir_pc, bt_5t25); else pass_cnt++;
        total_cnt++;
        if ({ps_pm_rd, ps_ir_vld, cpt_en, bt_26, ps_sleep} !== 5'b0) $display("FAIL areset_flags: got %b want 00000", {ps_pm_rd, ps_ir_vld, cpt_en, bt_26, ps_sleep}); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        if ({ps_pm_rd, ps_pm_addr, ps_ir_vld} !== {1'b1, 16'h0000, 1'b0}) $display("FAIL areset_reboot: got rd %b addr %h vld %b want 1 0000 0", ps_pm_rd, ps_pm_addr, ps_ir_vld); else pass_cnt++;
        total_cnt++;
    endtask

`ifdef PS_BKPT_EN
    task automatic test_bkpt();
        ps_bkpt_arm = 1'b1;
        ps_bkpt_addr = 16'h0004;
        do_reset();
        repeat (7) @(negedge clk); // cycle 7
        if ({ps_ir_vld, ps_ir_pc, cpt_en, ps_sleep, ps_pm_rd} !== {1'b1, 16'h0004, 1'b1, 1'b1, 1'b0}) $display("FAIL bkpt_hit: got vld %b pc %h cpt %b sleep %b rd %b want 1 0004 1 1 0", ps_ir_vld, ps_ir_pc, cpt_en, ps_sleep, ps_pm_rd); else pass_cnt++;
        total_cnt++;
        ps_bkpt_arm = 1'b0;
        @(negedge clk);
        if ({ps_ir_vld, ps_pm_rd, ps_pm_addr} !== {1'b0, 1'b0, 16'h0005}) $display("FAIL bkpt_halted: got vld %b rd %b addr %h want 0 0 0005", ps_ir_vld, ps_pm_rd, ps_pm_addr); else pass_cnt++;
        total_cnt++;
        ps_jmp_en = 1'b1;
        ps_jmp_addr = 16'h0000;
        @(negedge clk);
        ps_jmp_en = 1'b0;
        if ({ps_sleep, ps_pm_rd, ps_pm_addr} !== {1'b0, 1'b1, 16'h0000}) $display("FAIL bkpt_resume: got sleep %b rd %b addr %h want 0 1 0000", ps_sleep, ps_pm_rd, ps_pm_addr); else pass_cnt++;
        total_cnt++;
        repeat (2) @(negedge clk);
        if ({ps_ir_vld, ps_ir_pc} !== {1'b1, 16'h0000}) $display("FAIL bkpt_resume_ir: got vld %b pc %h want 1 0000", ps_ir_vld, ps_ir_pc); else pass_cnt++;
        total_cnt++;
    endtask
`endif

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i] = {5'b00001, i[0], 21'(i), 5'b00000};
        end
        mem[2] = 32'h0AAAAAA0;
        mem[5] = {5'b11111, 27'h0};

        test_reset();
        test_stream();
        test_idle();
        test_stall();
        test_jump();
        test_jump_sleep();
        test_async_reset();
`ifdef PS_BKPT_EN
        test_bkpt();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
